// File: rtl/lifo_stack_if.sv
// lifo_stack_if: push/pop handshake and status bundle for lifo_stack.
// master drives strobes and push data; slave (the stack) drives top-of-stack and status.
interface lifo_stack_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 20
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             PUSH_STB;
  logic [WIDTH-1:0] PUSH_DAT;
  logic             POP_STB;
  logic [WIDTH-1:0] POP_DAT;
  logic             EMPTY;
  logic             FULL;
  logic [CW-1:0]    COUNT;
  logic             OVF;
  logic             UDF;

  modport master (
    output PUSH_STB, PUSH_DAT, POP_STB,
    input  POP_DAT, EMPTY, FULL, COUNT, OVF, UDF
  );

  modport slave (
    input  PUSH_STB, PUSH_DAT, POP_STB,
    output POP_DAT, EMPTY, FULL, COUNT, OVF, UDF
  );
endinterface

// File: rtl/lifo_stack.sv
// lifo_stack: single-cycle push / pop / replace-top LIFO of DEPTH x WIDTH words.
// Top of stack is read combinationally; COUNT is the write pointer.
// Optional macro STACK_ERR_EN builds sticky overflow/underflow flags (OVF/UDF);
// without it both flags are tied low and illegal operations are silently ignored.
module lifo_stack #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 20
) (
  input logic         CLK,
  input logic         RST,
  lifo_stack_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Reject out-of-range depths at elaboration.
  if (DEPTH < 2 || DEPTH > 1024) begin : g_bad_depth
    $error("lifo_stack: DEPTH must be in 2..1024");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             empty_c;
  logic             full_c;
`ifdef STACK_ERR_EN
  logic             ovf_q;
  logic             udf_q;
  logic             ovf_set;
  logic             udf_set;
`endif

  // Status decode from the pointer.
  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));
  assign top_idx = AW'(count_q - CW'(1));

  // Next-pointer, write-port and error-set decode from the strobe pair.
  always_comb begin
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
`ifdef STACK_ERR_EN
    ovf_set = 1'b0;
    udf_set = 1'b0;
`endif
    unique case ({bus.PUSH_STB, bus.POP_STB})
      2'b10: begin
        if (!full_c) begin
          wr_en   = 1'b1;
          wr_idx  = AW'(count_q);
          count_d = count_q + CW'(1);
        end else begin
`ifdef STACK_ERR_EN
          ovf_set = 1'b1;
`endif
        end
      end
      2'b01: begin
        if (!empty_c) begin
          count_d = count_q - CW'(1);
        end else begin
`ifdef STACK_ERR_EN
          udf_set = 1'b1;
`endif
        end
      end
      2'b11: begin
        // Replace top; on an empty stack this degenerates to a plain push.
        wr_en = 1'b1;
        if (!empty_c) begin
          wr_idx = top_idx;
        end else begin
          wr_idx  = '0;
          count_d = CW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Pointer register; reset discards all entries immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage write port; contents are not reset since only entries below COUNT are visible.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_idx] <= bus.PUSH_DAT;
    end
  end

`ifdef STACK_ERR_EN
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (udf_set) udf_q <= 1'b1;
    end
  end

  assign bus.OVF = ovf_q;
  assign bus.UDF = udf_q;
`else
  assign bus.OVF = 1'b0;
  assign bus.UDF = 1'b0;
`endif

  // Empty stack reads all-zero, which is not a valid operator code.
  assign bus.POP_DAT = empty_c ? '0 : mem[top_idx];
  assign bus.EMPTY   = empty_c;
  assign bus.FULL    = full_c;
  assign bus.COUNT   = count_q;

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed stimulus against a queue-based reference of the stack,
// compared every cycle, plus hand-computed literal expectations.
module tb_lifo_stack;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned DEPTH = 20;

  logic CLK;
  logic RST;

  lifo_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference stack: last element of the queue is the top.
  logic [WIDTH-1:0] mq [$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned m_top();
    if (mq.size() == 0) return 0;
    return 32'(mq[mq.size()-1]);
  endfunction

  // Reference reset: entries and flags vanish as soon as RST falls.
  always @(negedge RST) begin
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  end

  // Reference update on each edge, then compare DUT against it just after.
  always @(posedge CLK) begin
    if (RST) begin
      if (bus.PUSH_STB && !bus.POP_STB) begin
        if (mq.size() < DEPTH) mq.push_back(bus.PUSH_DAT);
        else m_ovf = 1'b1;
      end else if (!bus.PUSH_STB && bus.POP_STB) begin
        if (mq.size() > 0) void'(mq.pop_back());
        else m_udf = 1'b1;
      end else if (bus.PUSH_STB && bus.POP_STB) begin
        if (mq.size() > 0) mq[mq.size()-1] = bus.PUSH_DAT;
        else mq.push_back(bus.PUSH_DAT);
      end
    end
    #1;
    if (chk_en) begin
      check("cyc_count", 32'(bus.COUNT), mq.size());
      check("cyc_pop_dat", 32'(bus.POP_DAT), m_top());
      check("cyc_empty", 32'(bus.EMPTY), 32'(mq.size() == 0));
      check("cyc_full", 32'(bus.FULL), 32'(mq.size() == DEPTH));
      check("cyc_ovf", 32'(bus.OVF), 32'(ERR_EN & m_ovf));
      check("cyc_udf", 32'(bus.UDF), 32'(ERR_EN & m_udf));
    end
  end

  // One operation: drive at a falling edge, hold across one rising edge, release.
  task automatic op(input bit push, input bit pop, input logic [WIDTH-1:0] dat);
    bus.PUSH_STB = push;
    bus.POP_STB  = pop;
    bus.PUSH_DAT = dat;
    @(negedge CLK);
    bus.PUSH_STB = 1'b0;
    bus.POP_STB  = 1'b0;
  endtask

  task automatic expect_state(input string name, input int unsigned cnt, input int unsigned dat,
                              input int unsigned emp, input int unsigned ful);
    check({name, "_count"}, 32'(bus.COUNT), cnt);
    check({name, "_pop_dat"}, 32'(bus.POP_DAT), dat);
    check({name, "_empty"}, 32'(bus.EMPTY), emp);
    check({name, "_full"}, 32'(bus.FULL), ful);
  endtask

  task automatic reset_sync();
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0;
    bus.PUSH_STB = 1'b0;
    bus.POP_STB  = 1'b0;
    bus.PUSH_DAT = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    chk_en = 1'b1;
    @(negedge CLK);

    // Reset then idle.
    expect_state("reset", 0, 0, 1, 0);
    check("reset_ovf", 32'(bus.OVF), 0);
    check("reset_udf", 32'(bus.UDF), 0);

    // Push 010, 001; pop twice.
    op(1, 0, 3'b010);
    op(1, 0, 3'b001);
    expect_state("push2", 2, 1, 0, 0);
    op(0, 1, 3'b000);
    expect_state("pop1", 1, 2, 0, 0);
    op(0, 1, 3'b000);
    expect_state("pop2", 0, 0, 1, 0);

    // Replace top of [010,001] with 011.
    op(1, 0, 3'b010);
    op(1, 0, 3'b001);
    op(1, 1, 3'b011);
    expect_state("replace", 2, 3, 0, 0);
    op(0, 1, 3'b000);
    expect_state("replace_pop", 1, 2, 0, 0);
    op(0, 1, 3'b000);
    expect_state("replace_empty", 0, 0, 1, 0);

    // Fill with i mod 8, then overflow push of 111.
    for (int i = 0; i < 20; i++) op(1, 0, 3'(i % 8));
    expect_state("fill", 20, 3, 0, 1);
    op(1, 0, 3'b111);
    expect_state("ovf_push", 20, 3, 0, 1);
    check("ovf_flag", 32'(bus.OVF), 32'(ERR_EN));

    // Replace while full is still legal.
    op(1, 1, 3'b101);
    expect_state("full_replace", 20, 5, 0, 1);

    // Level-sensitive pop held for 20 cycles drains the stack.
    bus.POP_STB = 1'b1;
    repeat (20) @(negedge CLK);
    bus.POP_STB = 1'b0;
    expect_state("drain", 0, 0, 1, 0);
    check("drain_udf", 32'(bus.UDF), 0);

    // Underflow on a freshly reset stack.
    reset_sync();
    @(negedge CLK);
    check("rst2_ovf", 32'(bus.OVF), 0);
    op(0, 1, 3'b000);
    op(0, 1, 3'b000);
    expect_state("udf", 0, 0, 1, 0);
    check("udf_flag", 32'(bus.UDF), 32'(ERR_EN));
    op(1, 0, 3'b100);
    expect_state("udf_push", 1, 4, 0, 0);
    check("udf_sticky", 32'(bus.UDF), 32'(ERR_EN));

    // Both strobes on an empty stack act as a push, no underflow set.
    op(0, 1, 3'b000);
    reset_sync();
    @(negedge CLK);
    op(1, 1, 3'b110);
    expect_state("both_empty", 1, 6, 0, 0);
    check("both_empty_udf", 32'(bus.UDF), 0);

    // Async reset between edges with five entries.
    for (int i = 0; i < 4; i++) op(1, 0, 3'(i + 1));
    expect_state("pre_async", 5, 4, 0, 0);
    #2;
    RST = 1'b0;
    #1;
    expect_state("async_rst", 0, 0, 1, 0);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    op(1, 0, 3'b001);
    expect_state("post_async", 1, 1, 0, 0);

    repeat (2) @(negedge CLK);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
